// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded control and forwarded operands for EX,
// turns register-file pauses into bubbles, honours flush/EX stall, and counts bubbles/flushes.
module id_ex_stage #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    input  logic             flush,
    input  logic             ex_stall,
    input  logic             id_valid,
    input  logic [DW-1:0]    id_pc,
    input  logic [DW-1:0]    id_r1,
    input  logic [DW-1:0]    id_r2,
    input  logic [DW-1:0]    id_imm,
    input  logic [4:0]       id_wa,
    input  logic             id_we,
    input  logic [1:0]       id_cregwd,
    input  logic [3:0]       id_aluop,
    input  logic             id_mem_we,
    input  logic             id_ra_we,
    input  logic [DW-1:0]    id_ra,
    output logic             stall_id,
    output logic             ex_valid,
    output logic [DW-1:0]    ex_pc,
    output logic [DW-1:0]    ex_r1,
    output logic [DW-1:0]    ex_r2,
    output logic [DW-1:0]    ex_imm,
    output logic [DW-1:0]    ex_ra,
    output logic [4:0]       wa_ex,
    output logic             we_ex,
    output logic [1:0]       cregwd_ex,
    output logic [3:0]       ex_aluop,
    output logic             ex_mem_we,
    output logic             ex_ra_we,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
        logic [DW-1:0] imm;
        logic [DW-1:0] ra;
        logic [4:0]    wa;
        logic          we;
        logic [1:0]    cregwd;
        logic [3:0]    aluop;
        logic          mem_we;
        logic          ra_we;
    } ex_pkt_t;

    ex_pkt_t id_pkt, ex_q;

    // Enables are qualified by id_valid so an empty slot can never write state.
    always_comb begin
        id_pkt        = '0;
        id_pkt.valid  = id_valid;
        id_pkt.pc     = id_pc;
        id_pkt.r1     = id_r1;
        id_pkt.r2     = id_r2;
        id_pkt.imm    = id_imm;
        id_pkt.ra     = id_ra;
        id_pkt.wa     = id_wa;
        id_pkt.we     = id_we & id_valid;
        id_pkt.cregwd = id_cregwd;
        id_pkt.aluop  = id_aluop;
        id_pkt.mem_we = id_mem_we & id_valid;
        id_pkt.ra_we  = id_ra_we & id_valid;
    end

    // Flush wins over a pause so the fetch redirect is not held off.
    assign stall_id = ex_stall | (pause & ~flush);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q       <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (flush) begin
            ex_q <= '0;
            if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end else if (ex_stall) begin
            ex_q <= ex_q;
        end else if (pause) begin
            ex_q <= '0;
            if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
        end else begin
            ex_q <= id_pkt;
        end
    end

    assign ex_valid  = ex_q.valid;
    assign ex_pc     = ex_q.pc;
    assign ex_r1     = ex_q.r1;
    assign ex_r2     = ex_q.r2;
    assign ex_imm    = ex_q.imm;
    assign ex_ra     = ex_q.ra;
    assign wa_ex     = ex_q.wa;
    assign we_ex     = ex_q.we;
    assign cregwd_ex = ex_q.cregwd;
    assign ex_aluop  = ex_q.aluop;
    assign ex_mem_we = ex_q.mem_we;
    assign ex_ra_we  = ex_q.ra_we;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage plus hand sequences for reset,
// EX-stall freeze and bubble counter saturation.
module tb_id_ex_stage;

    localparam int DW    = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             pause, flush, ex_stall, id_valid;
    logic [DW-1:0]    id_pc, id_r1, id_r2, id_imm, id_ra;
    logic [4:0]       id_wa;
    logic             id_we;
    logic [1:0]       id_cregwd;
    logic [3:0]       id_aluop;
    logic             id_mem_we, id_ra_we;
    logic             stall_id, ex_valid;
    logic [DW-1:0]    ex_pc, ex_r1, ex_r2, ex_imm, ex_ra;
    logic [4:0]       wa_ex;
    logic             we_ex;
    logic [1:0]       cregwd_ex;
    logic [3:0]       ex_aluop;
    logic             ex_mem_we, ex_ra_we;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    id_ex_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pause(pause), .flush(flush), .ex_stall(ex_stall),
        .id_valid(id_valid), .id_pc(id_pc), .id_r1(id_r1), .id_r2(id_r2),
        .id_imm(id_imm), .id_wa(id_wa), .id_we(id_we), .id_cregwd(id_cregwd),
        .id_aluop(id_aluop), .id_mem_we(id_mem_we), .id_ra_we(id_ra_we), .id_ra(id_ra),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_r1(ex_r1),
        .ex_r2(ex_r2), .ex_imm(ex_imm), .ex_ra(ex_ra), .wa_ex(wa_ex), .we_ex(we_ex),
        .cregwd_ex(cregwd_ex), .ex_aluop(ex_aluop), .ex_mem_we(ex_mem_we),
        .ex_ra_we(ex_ra_we), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        flush, ex_stall, pause, valid;
        logic [31:0] pc, r1;
        logic [4:0]  wa;
        logic        we;
        logic [1:0]  cr;
        logic        mw, rw;
        logic        s_id, e_valid;
        logic [31:0] e_pc, e_r1;
        logic [4:0]  e_wa;
        logic        e_we;
        logic [1:0]  e_cr;
        logic        e_mw, e_rw;
        logic [15:0] e_b, e_f;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Secondary ID fields are derived from the PC; a zero PC means an all-zero slot.
    task automatic drive(input vec_t v);
        flush     = v.flush;
        ex_stall  = v.ex_stall;
        pause     = v.pause;
        id_valid  = v.valid;
        id_pc     = v.pc;
        id_r1     = v.r1;
        id_r2     = v.pc + 32'd1;
        id_imm    = v.pc + 32'd2;
        id_ra     = v.pc + 32'd3;
        id_aluop  = v.pc[5:2];
        id_wa     = v.wa;
        id_we     = v.we;
        id_cregwd = v.cr;
        id_mem_we = v.mw;
        id_ra_we  = v.rw;
    endtask

    task automatic check_outs(input string tag, input logic e_valid, input logic [31:0] e_pc,
                              input logic [31:0] e_r1, input logic [4:0] e_wa, input logic e_we,
                              input logic [1:0] e_cr, input logic e_mw, input logic e_rw,
                              input logic [15:0] e_b, input logic [15:0] e_f);
        logic [31:0] e_r2, e_imm, e_ra;
        logic [3:0]  e_op;
        e_r2  = (e_pc == 0) ? 32'd0 : e_pc + 32'd1;
        e_imm = (e_pc == 0) ? 32'd0 : e_pc + 32'd2;
        e_ra  = (e_pc == 0) ? 32'd0 : e_pc + 32'd3;
        e_op  = e_pc[5:2];
        chk({tag, " ex_valid"},   64'(ex_valid),   64'(e_valid));
        chk({tag, " ex_pc"},      64'(ex_pc),      64'(e_pc));
        chk({tag, " ex_r1"},      64'(ex_r1),      64'(e_r1));
        chk({tag, " ex_r2"},      64'(ex_r2),      64'(e_r2));
        chk({tag, " ex_imm"},     64'(ex_imm),     64'(e_imm));
        chk({tag, " ex_ra"},      64'(ex_ra),      64'(e_ra));
        chk({tag, " ex_aluop"},   64'(ex_aluop),   64'(e_op));
        chk({tag, " wa_ex"},      64'(wa_ex),      64'(e_wa));
        chk({tag, " we_ex"},      64'(we_ex),      64'(e_we));
        chk({tag, " cregwd_ex"},  64'(cregwd_ex),  64'(e_cr));
        chk({tag, " ex_mem_we"},  64'(ex_mem_we),  64'(e_mw));
        chk({tag, " ex_ra_we"},   64'(ex_ra_we),   64'(e_rw));
        chk({tag, " bubble_cnt"}, 64'(bubble_cnt), 64'(e_b));
        chk({tag, " flush_cnt"},  64'(flush_cnt),  64'(e_f));
    endtask

    initial begin
        vec_t v;
        // flush,ex_stall,pause,valid, pc,r1,wa,we,cr,mw,rw, s_id, e_valid,e_pc,e_r1,e_wa,e_we,e_cr,e_mw,e_rw, e_b,e_f
        vecs[0]  = '{0,0,0,1, 'h100,'hDEAD, 8,1,0,0,0, 0, 1,'h100,'hDEAD, 8,1,0,0,0, 0,0};
        vecs[1]  = '{0,0,0,1, 'h104,'h11,   3,1,2,0,0, 0, 1,'h104,'h11,   3,1,2,0,0, 0,0};
        vecs[2]  = '{0,0,1,1, 'h108,'h22,   9,1,0,0,0, 1, 0,0,0,          0,0,0,0,0, 1,0};
        vecs[3]  = '{0,0,0,1, 'h108,'h22,   9,1,0,0,0, 0, 1,'h108,'h22,   9,1,0,0,0, 1,0};
        vecs[4]  = '{1,0,1,1, 'h10C,'h33,  10,1,0,0,0, 0, 0,0,0,          0,0,0,0,0, 1,1};
        vecs[5]  = '{0,0,0,1, 'h110,'h44,   4,1,1,1,1, 0, 1,'h110,'h44,   4,1,1,1,1, 1,1};
        vecs[6]  = '{0,1,1,1, 'h200,'h55,   6,1,0,0,0, 1, 1,'h110,'h44,   4,1,1,1,1, 1,1};
        vecs[7]  = vecs[6];
        vecs[8]  = vecs[6];
        vecs[9]  = '{0,0,1,1, 'h200,'h55,   6,1,0,0,0, 1, 0,0,0,          0,0,0,0,0, 2,1};
        vecs[10] = '{0,0,0,1, 'h200,'h55,   6,1,0,0,0, 0, 1,'h200,'h55,   6,1,0,0,0, 2,1};
        vecs[11] = '{0,0,0,0, 'h300,'h66,   7,1,1,1,1, 0, 0,'h300,'h66,   7,0,1,0,0, 2,1};
        vecs[12] = '{1,1,1,1, 'h400,'h77,  11,1,0,0,0, 1, 0,0,0,          0,0,0,0,0, 2,2};
        vecs[13] = '{0,1,0,1, 'h400,'h77,  11,1,0,0,0, 1, 0,0,0,          0,0,0,0,0, 2,2};

        // Power-on reset
        rst = 1'b0;
        v = vecs[0];
        v.wa = 5;
        drive(v);
        #1;
        check_outs("por", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load an instruction with wa=5, then reset mid-cycle while EX is stalled
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
        check_outs("pre_rst", 1, 'h100, 'hDEAD, 5, 1, 0, 0, 0, 0, 0);
        @(negedge clk) ex_stall = 1'b1;
        @(posedge clk) #2;
        rst = 1'b0;
        #1;
        check_outs("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        v = vecs[0];
        v.pc = 'h40;
        drive(v);
        @(posedge clk) #1;
        check_outs("rst_release", 1, 'h40, 'hDEAD, 8, 1, 0, 0, 0, 0, 0);

        // Table: stall_id checked before the edge, registered outputs just after it
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d stall_id", i), 64'(stall_id), 64'(vecs[i].s_id));
            @(posedge clk) #1;
            check_outs($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_r1,
                       vecs[i].e_wa, vecs[i].e_we, vecs[i].e_cr, vecs[i].e_mw, vecs[i].e_rw,
                       vecs[i].e_b, vecs[i].e_f);
        end

        // Bubble counter saturation: counter is 2 here, run up to 0xFFFE then past the top
        @(negedge clk);
        v = vecs[9];
        drive(v);
        repeat (65532) @(posedge clk);
        #1;
        chk("sat bubble_cnt 0xFFFE", 64'(bubble_cnt), 64'hFFFE);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk) #1;
            chk($sformatf("sat%0d bubble_cnt", k), 64'(bubble_cnt), 64'hFFFF);
            chk($sformatf("sat%0d we_ex", k), 64'(we_ex), 64'h0);
            chk($sformatf("sat%0d ex_valid", k), 64'(ex_valid), 64'h0);
        end
        chk("sat flush_cnt", 64'(flush_cnt), 64'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
